hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage RV32I_Zicsr core. It decides stall and flush for every
//  pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and selects the PC source.
//  It detects load-use hazards that the EX-stage forwarding mux cannot resolve, and freezes on a
//  busy data memory, with a watchdog. It redirects on a taken branch or a trap/mret, and drains
//  the pipeline after a trap so that CSR state commits before fetch resumes.
// PARAMETERS
//  DRAIN_CYC    2    cycles IF stays stalled after a trap/mret redirect (1..15)
//  MEM_TIMEOUT  255  max consecutive i_dmem_busy cycles before o_bus_err; 0 = watchdog off
// PORTS
//  i_clk           in   1        core clock; all state changes on its rising edge
//  i_rst_n         in   1        reset, asynchronous assert, active-low
//  i_rs1_addr_id   in   `XADDR   rs1 address of the instruction in ID
//  i_rs2_addr_id   in   `XADDR   rs2 address of the instruction in ID
//  i_rs1_use_id    in   1        ID instruction reads rs1
//  i_rs2_use_id    in   1        ID instruction reads rs2
//  i_rd_addr_ex    in   `XADDR   rd address of the instruction in EX
//  i_rd_wr_en_ex   in   1        EX instruction writes rd
//  i_is_load_ex    in   1        EX instruction is a load
//  i_br_taken_ex   in   1        branch/jump in EX resolved taken
//  i_dmem_busy     in   1        MEM-stage access not yet complete
//  i_trap_mem      in   1        exception/ecall retiring from MEM
//  i_mret_mem      in   1        mret retiring from MEM
//  o_stall_if/id/ex/mem  out 1 each  hold PC / IF-ID / ID-EX / EX-MEM registers
//  o_flush_id/ex/mem/wb  out 1 each  load bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
//  o_pc_src        out  2        00 seq, 01 branch target, 10 mtvec, 11 mepc
//  o_bus_err       out  1        one-cycle pulse: data memory watchdog expired
// BEHAVIOUR
//  - State (registered): INIT, RUN, MEMWAIT, DRAIN. Outputs are combinational from state and inputs.
//  - Reset (async, i_rst_n=0): state=INIT, wait/drain counters=0. In INIT: all o_flush_*=1,
//    all o_stall_*=0, o_pc_src=00, o_bus_err=0. INIT->RUN unconditionally on the first edge after release.
//  - Priority, highest first, evaluated every cycle in RUN/MEMWAIT: trap/mret > timeout > dmem busy >
//    branch taken > load-use.
//  - Trap/mret: o_flush_id/ex/mem=1, o_pc_src=10 (trap) or 11 (mret; trap wins if both are asserted).
//    Then go to DRAIN with cnt=DRAIN_CYC. Any busy access is abandoned (EX-MEM flushed).
//  - DRAIN: o_stall_if=1, o_flush_id=1; cnt decrements each cycle; at cnt==1 go to RUN.
//    i_trap_mem in DRAIN is ignored (the pipe holds only bubbles).
//  - Busy (i_dmem_busy=1): o_stall_if/id/ex/mem=1, o_flush_wb=1; state MEMWAIT; wcnt increments.
//    When busy drops, the same cycle gives normal RUN decode and the next state is RUN; wcnt clears.
//  - Timeout: MEM_TIMEOUT!=0 and wcnt==MEM_TIMEOUT-1 with busy still set: o_bus_err=1 for 1 cycle,
//    treated as a trap (pc_src=10, flushes, DRAIN). wcnt saturates and never wraps.
//  - A taken branch during busy is deferred: EX is frozen, and the branch is re-evaluated when busy
//    drops. No redirect happens while stalled.
//  - Branch taken (RUN, no busy): o_flush_id=1, o_flush_ex=1, o_pc_src=01, 1 cycle. This overrides
//    load-use, because the ID instruction is wrong-path.
//  - Load-use: i_is_load_ex & i_rd_wr_en_ex & (i_rd_addr_ex!=0) & ((i_rs1_use_id & rs1==rd) |
//    (i_rs2_use_id & rs2==rd)). Response: o_stall_if=1, o_stall_id=1, o_flush_ex=1 for exactly
//    1 cycle. A rd of x0 never stalls.
//  - Otherwise (RUN): all stalls and flushes are 0, o_pc_src=00.
//  - A stall and a flush on the same register never coexist except o_stall_if with o_flush_id (DRAIN).
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs or_stall_cnt[31:0] and or_flush_cnt[31:0], both
//    registered and cleared by reset.
//    or_stall_cnt counts +1 per cycle with any o_stall_*=1.
//    or_flush_cnt counts +1 per branch/trap/mret redirect.
//    Both wrap at 2^32.
//  HAZARD_PERF_CNT_EN undefined: these ports and registers do not exist. Behaviour is otherwise identical.
// TESTING
//  1 Reset low mid-MEMWAIT -> all o_flush_*=1, stalls=0 immediately; 1 cycle after release state RUN.
//  2 EX lw x5, ID add x6,x5,x1 -> 1 cycle stall_if/id + flush_ex; lw x0 + use x0 -> no stall.
//  3 Branch taken in EX with ID load-use on the same cycle -> flush_id/ex, pc_src=01, no stall.
//  4 i_dmem_busy high 3 cycles + taken branch in EX -> 3 stall cycles, then redirect on cycle 4.
//  5 i_trap_mem, DRAIN_CYC=2 -> pc_src=10 + flushes, then 2 cycles stall_if/flush_id, then RUN.
//  6 MEM_TIMEOUT=4, busy held -> o_bus_err pulse on 4th busy cycle, pc_src=10, DRAIN entered.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard/sequencer signal bundle between the pipeline datapath and hazard_ctrl.
// master = pipeline side (drives hazard inputs), slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0] i_rs1_addr_id;
  logic [4:0] i_rs2_addr_id;
  logic       i_rs1_use_id;
  logic       i_rs2_use_id;
  logic [4:0] i_rd_addr_ex;
  logic       i_rd_wr_en_ex;
  logic       i_is_load_ex;
  logic       i_br_taken_ex;
  logic       i_dmem_busy;
  logic       i_trap_mem;
  logic       i_mret_mem;
  logic       o_stall_if;
  logic       o_stall_id;
  logic       o_stall_ex;
  logic       o_stall_mem;
  logic       o_flush_id;
  logic       o_flush_ex;
  logic       o_flush_mem;
  logic       o_flush_wb;
  logic [1:0] o_pc_src;
  logic       o_bus_err;

  modport master (
    output i_rs1_addr_id, i_rs2_addr_id, i_rs1_use_id, i_rs2_use_id,
           i_rd_addr_ex, i_rd_wr_en_ex, i_is_load_ex, i_br_taken_ex,
           i_dmem_busy, i_trap_mem, i_mret_mem,
    input  o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
           o_flush_id, o_flush_ex, o_flush_mem, o_flush_wb,
           o_pc_src, o_bus_err
  );

  modport slave (
    input  i_rs1_addr_id, i_rs2_addr_id, i_rs1_use_id, i_rs2_use_id,
           i_rd_addr_ex, i_rd_wr_en_ex, i_is_load_ex, i_br_taken_ex,
           i_dmem_busy, i_trap_mem, i_mret_mem,
    output o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
           o_flush_id, o_flush_ex, o_flush_mem, o_flush_wb,
           o_pc_src, o_bus_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stall, dmem freeze with watchdog, branch/trap redirect, drain.
// Optional HAZARD_PERF_CNT_EN adds or_stall_cnt / or_flush_cnt performance counters.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYC   = 2,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   or_stall_cnt,
  output logic [31:0]   or_flush_cnt
`endif
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MEMWAIT, S_DRAIN} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;

  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex, flush_mem, flush_wb;
  logic [1:0] pc_src;
  logic       bus_err;
  logic       load_use, timeout;

  assign load_use = hz.i_is_load_ex && hz.i_rd_wr_en_ex && (hz.i_rd_addr_ex != '0) &&
                    ((hz.i_rs1_use_id && (hz.i_rs1_addr_id == hz.i_rd_addr_ex)) ||
                     (hz.i_rs2_use_id && (hz.i_rs2_addr_id == hz.i_rd_addr_ex)));

  assign timeout = (MEM_TIMEOUT != 0) && hz.i_dmem_busy && (wcnt == WCNT_LAST);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wcnt_nx   = wcnt;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    pc_src    = 2'b00;
    bus_err   = 1'b0;
    unique case (state)
      S_INIT: begin
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        flush_mem = 1'b1;
        flush_wb  = 1'b1;
        state_nx  = S_RUN;
      end
      S_DRAIN: begin
        // Pipe holds only bubbles here, so every request input is ignored.
        stall_if = 1'b1;
        flush_id = 1'b1;
        cnt_nx   = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = S_RUN;
      end
      default: begin
        // RUN and MEMWAIT decode identically; MEMWAIT only labels an ongoing freeze.
        if (hz.i_trap_mem || hz.i_mret_mem || timeout) begin
          flush_id  = 1'b1;
          flush_ex  = 1'b1;
          flush_mem = 1'b1;
          pc_src    = (hz.i_trap_mem || !hz.i_mret_mem) ? 2'b10 : 2'b11;
          bus_err   = !(hz.i_trap_mem || hz.i_mret_mem);
          state_nx  = S_DRAIN;
          cnt_nx    = DRAIN_INIT;
          wcnt_nx   = '0;
        end else if (hz.i_dmem_busy) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          flush_wb  = 1'b1;
          state_nx  = S_MEMWAIT;
          wcnt_nx   = (wcnt == '1) ? wcnt : wcnt + 1'b1;
        end else begin
          state_nx = S_RUN;
          wcnt_nx  = '0;
          if (hz.i_br_taken_ex) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            pc_src   = 2'b01;
          end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      wcnt  <= wcnt_nx;
    end
  end

  assign hz.o_stall_if  = stall_if;
  assign hz.o_stall_id  = stall_id;
  assign hz.o_stall_ex  = stall_ex;
  assign hz.o_stall_mem = stall_mem;
  assign hz.o_flush_id  = flush_id;
  assign hz.o_flush_ex  = flush_ex;
  assign hz.o_flush_mem = flush_mem;
  assign hz.o_flush_wb  = flush_wb;
  assign hz.o_pc_src    = pc_src;
  assign hz.o_bus_err   = bus_err;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      or_stall_cnt <= '0;
      or_flush_cnt <= '0;
    end else begin
      if (stall_if || stall_id || stall_ex || stall_mem) or_stall_cnt <= or_stall_cnt + 32'd1;
      if (pc_src != 2'b00) or_flush_cnt <= or_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic vs a rule-level model.
module tb_hazard_ctrl;
  localparam int DRAIN = 2;
  localparam int TO    = 4;

  typedef struct packed {
    logic [3:0] stall;   // {if, id, ex, mem}
    logic [3:0] flush;   // {id, ex, mem, wb}
    logic [1:0] pc;
    logic       berr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.DRAIN_CYC(DRAIN), .MEM_TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .or_stall_cnt (stall_cnt),
    .or_flush_cnt (flush_cnt)
`endif
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model: "still in reset aftermath", cycles of drain left, consecutive busy cycles seen.
  bit m_init  = 1'b1;
  int m_drain = 0;
  int m_busy  = 0;

  task automatic step(input bit rst_low, input bit trap, input bit mret, input bit busy,
                      input bit br, input bit ld, input bit wr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    hz.i_trap_mem    = trap;
    hz.i_mret_mem    = mret;
    hz.i_dmem_busy   = busy;
    hz.i_br_taken_ex = br;
    hz.i_is_load_ex  = ld;
    hz.i_rd_wr_en_ex = wr;
    hz.i_rd_addr_ex  = rd;
    hz.i_rs1_addr_id = rs1;
    hz.i_rs2_addr_id = rs2;
    hz.i_rs1_use_id  = u1;
    hz.i_rs2_use_id  = u2;
    if (rst_low) begin
      rst_n   = 1'b0;
      m_init  = 1'b1;
      m_drain = 0;
      m_busy  = 0;
    end else begin
      rst_n = 1'b1;
    end
    e  = '0;
    lu = ld && wr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (m_init) begin
      e.flush = 4'b1111;
      if (!rst_low) m_init = 1'b0;
    end else if (m_drain > 0) begin
      e.stall = 4'b1000;
      e.flush = 4'b1000;
      m_drain--;
    end else if (trap || mret) begin
      e.flush = 4'b1110;
      e.pc    = trap ? 2'd2 : 2'd3;
      m_drain = DRAIN;
      m_busy  = 0;
    end else if (busy && (m_busy + 1 == TO)) begin
      e.berr  = 1'b1;
      e.pc    = 2'd2;
      e.flush = 4'b1110;
      m_drain = DRAIN;
      m_busy  = 0;
    end else if (busy) begin
      e.stall = 4'b1111;
      e.flush = 4'b0001;
      m_busy++;
    end else begin
      m_busy = 0;
      if (br) begin
        e.flush = 4'b1100;
        e.pc    = 2'd1;
      end else if (lu) begin
        e.stall = 4'b1100;
        e.flush = 4'b0100;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per falling edge.
  always @(negedge clk) begin
    exp_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.stall = {hz.o_stall_if, hz.o_stall_id, hz.o_stall_ex, hz.o_stall_mem};
      a.flush = {hz.o_flush_id, hz.o_flush_ex, hz.o_flush_mem, hz.o_flush_wb};
      a.pc    = hz.o_pc_src;
      a.berr  = hz.o_bus_err;
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL ctrl_out cyc=%0d actual stall=%b flush=%b pc=%b berr=%b required stall=%b flush=%b pc=%b berr=%b",
                 cyc, a.stall, a.flush, a.pc, a.berr, e.stall, e.flush, e.pc, e.berr);
      end
    end
  end

  initial begin
    // Reset, then reset asserted again while frozen on a busy access.
    step(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    // Load-use on rs1, on rs2, no stall via x0, no stall when store-like (no rd write).
    step(0, 0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1, 5'd7, 5'd2, 5'd7, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd5, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd5, 0, 0);
    // Branch wins over simultaneous load-use.
    step(0, 0, 0, 0, 1, 1, 1, 5'd5, 5'd5, 5'd1, 1, 1);
    idle(1);
    // Busy 3 cycles with a pending taken branch, redirect on the 4th.
    repeat (3) step(0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    // Trap, drain with a trap ignored inside it, then mret and trap+mret together.
    step(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);
    step(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);
    // Watchdog: busy held, bus_err on the 4th busy cycle, then drain.
    repeat (6) step(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);
    // Trap while frozen abandons the access.
    step(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 80,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_queue actual pending=%0d required pending=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
